// File: rtl/register_writeback_if.sv
// register_writeback_if: request, load-data and register-file write signals of register_writeback.
//
// Signal groups (named from the writeback block's side):
//   Request:    req_valid, req_ready, instruction[27:0], result_lo, result_hi, base_value
//   Load data:  ld_valid, ld_ready, ld_data
//   Reg write:  wr_en, wr_addr[3:0], wr_data, pc_written
//   Status:     busy
//
// Modports:
//   master: upstream execute/memory side. Drives the request and load data, and observes the rest.
//   slave:  the writeback block itself.
interface register_writeback_if #(
   parameter int unsigned DATA_W = 32
);

   logic              req_valid;
   logic              req_ready;
   logic [27:0]       instruction;
   logic [DATA_W-1:0] result_lo;
   logic [DATA_W-1:0] result_hi;
   logic [DATA_W-1:0] base_value;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              wr_en;
   logic [3:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              pc_written;
   logic              busy;

   modport master (
      output req_valid, instruction, result_lo, result_hi, base_value, ld_valid, ld_data,
      input  req_ready, ld_ready, wr_en, wr_addr, wr_data, pc_written, busy
   );

   modport slave (
      input  req_valid, instruction, result_lo, result_hi, base_value, ld_valid, ld_data,
      output req_ready, ld_ready, wr_en, wr_addr, wr_data, pc_written, busy
   );

endinterface

// File: rtl/register_writeback.sv
// register_writeback: destination-side decoder and write sequencer for one completed ARM instruction.
//
// The block decodes which registers an accepted instruction writes. It then issues those writes
// on the register file's single write port, one register per cycle. The request handshake stays
// low until the last write has been issued.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  register_writeback_if.slave, carrying these signals:
//        req_valid/req_ready                 instruction handshake (ready only in StIdle)
//        instruction[27:0]                   instruction without its condition field
//        result_lo, result_hi, base_value    execute results and the updated base address
//        ld_valid/ld_ready/ld_data           load data beats (ready only in StLoad)
//        wr_en/wr_addr/wr_data               registered register-file write port
//        pc_written                          pulses together with any write to R15
//        busy                                inverse of req_ready
module register_writeback #(
   parameter int unsigned DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   register_writeback_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StBase,
      StPrimary,
      StSecond,
      StLoad
   } state_e;

   state_e state_q, state_d;

   // Registers that still have to be filled from load beats. They are served lowest-first.
   logic [15:0]       pend_q, pend_d;
   // Long-multiply high half. It is captured at accept and written one cycle after RdLo.
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [3:0]        rdhi_q, rdhi_d;
   logic              long_q, long_d;

   logic              wr_en_q, wr_en_d;
   logic [3:0]        wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              pc_written_q, pc_written_d;

   // Decode results for the instruction currently presented on the request port.
   logic        dec_base_en;
   logic        dec_prim_en;
   logic        dec_long;
   logic [3:0]  dec_prim_addr;
   logic [3:0]  dec_hi_addr;
   logic [15:0] dec_pend;

   logic [3:0]  low_idx;
   logic [15:0] pend_left;

   logic [27:0] ins;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic        bit_l;
   logic        bit_p;
   logic        bit_w;
   logic [3:0]  opcode;

   assign ins    = bus.instruction;
   assign rn     = ins[19:16];
   assign rd     = ins[15:12];
   assign bit_l  = ins[20];
   assign bit_p  = ins[24];
   assign bit_w  = ins[21];
   assign opcode = ins[24:21];

   // Destination decode. The branches are checked in priority order, because the earlier
   // encodings overlap with the data-processing and transfer spaces.
   always_comb begin
      dec_base_en   = 1'b0;
      dec_prim_en   = 1'b0;
      dec_long      = 1'b0;
      dec_prim_addr = 4'd0;
      dec_hi_addr   = 4'd0;
      dec_pend      = 16'd0;

      if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001) begin
         // MUL/MLA: Rd is held in bits [19:16].
         dec_prim_en   = 1'b1;
         dec_prim_addr = rn;
      end else if (ins[27:23] == 5'b00001 && ins[7:4] == 4'b1001) begin
         // Long multiply: RdLo first, then RdHi.
         dec_prim_en   = 1'b1;
         dec_prim_addr = rd;
         dec_long      = 1'b1;
         dec_hi_addr   = rn;
      end else if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00 && ins[11:4] == 8'h09) begin
         // Swap: the destination is filled by one load beat.
         dec_pend[rd] = 1'b1;
      end else if (ins[27:4] == 24'h12FFF1) begin
         // BX writes no register.
      end else if (ins[27:25] == 3'b000 && ins[7] && ins[4] && ins[6:5] != 2'b00) begin
         // Halfword and signed transfers.
         if (bit_l) begin
            dec_pend[rd] = 1'b1;
         end
         dec_base_en = !bit_p || bit_w;
      end else if (ins[27:26] == 2'b00) begin
         if (opcode[3:2] == 2'b10) begin
            // Compare ops (S=1) and MSR write nothing. MRS writes Rd.
            if (!bit_l && !opcode[0]) begin
               dec_prim_en   = 1'b1;
               dec_prim_addr = rd;
            end
         end else begin
            dec_prim_en   = 1'b1;
            dec_prim_addr = rd;
         end
      end else if (ins[27:26] == 2'b01 && !(ins[25] && ins[4])) begin
         // Single data transfer.
         if (bit_l) begin
            dec_pend[rd] = 1'b1;
         end
         dec_base_en = !bit_p || bit_w;
      end else if (ins[27:25] == 3'b100) begin
         // Block transfer: the base write comes first, then one beat per listed register.
         dec_base_en = bit_w;
         if (bit_l) begin
            dec_pend = ins[15:0];
         end
      end else if (ins[27:25] == 3'b101) begin
         // Branch with link writes the return address to R14.
         dec_prim_en   = bit_p;
         dec_prim_addr = 4'd14;
      end
      // Undefined, coprocessor and SWI encodings write nothing.
   end

   // Finds the lowest pending register. The loop runs from 15 down to 0, so the lowest set bit
   // is the last match.
   always_comb begin
      low_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pend_q[i]) begin
            low_idx = 4'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves the registers still to be served.
   assign pend_left = pend_q & (pend_q - 16'd1);

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      hi_d      = hi_q;
      rdhi_d    = rdhi_q;
      long_d    = long_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               pend_d = dec_pend;
               hi_d   = bus.result_hi;
               rdhi_d = dec_hi_addr;
               long_d = dec_long;
               if (dec_base_en) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = rn;
                  wr_data_d = bus.base_value;
                  state_d   = StBase;
               end else if (dec_prim_en) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = dec_prim_addr;
                  wr_data_d = bus.result_lo;
                  state_d   = StPrimary;
               end else if (dec_pend != 16'd0) begin
                  state_d = StLoad;
               end
            end
         end
         StBase: begin
            state_d = (pend_q != 16'd0) ? StLoad : StIdle;
         end
         StPrimary: begin
            if (long_q) begin
               wr_en_d   = 1'b1;
               wr_addr_d = rdhi_q;
               wr_data_d = hi_q;
               state_d   = StSecond;
            end else begin
               state_d = StIdle;
            end
         end
         StSecond: begin
            state_d = StIdle;
         end
         StLoad: begin
            if (bus.ld_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = low_idx;
               wr_data_d = bus.ld_data;
               pend_d    = pend_left;
               // The last beat's write appears while req_ready is already high again.
               if (pend_left == 16'd0) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign pc_written_d = wr_en_d && (wr_addr_d == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         pend_q       <= 16'd0;
         hi_q         <= '0;
         rdhi_q       <= 4'd0;
         long_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 4'd0;
         wr_data_q    <= '0;
         pc_written_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         hi_q         <= hi_d;
         rdhi_q       <= rdhi_d;
         long_q       <= long_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         pc_written_q <= pc_written_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.busy       = (state_q != StIdle);
   assign bus.ld_ready   = (state_q == StLoad);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.pc_written = pc_written_q;

endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   register_writeback_if #(.DATA_W(32)) bus ();

   register_writeback #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [27:0] ins, input logic [31:0] lo, input logic [31:0] hi,
                           input logic [31:0] base);
      bus.req_valid   = 1'b1;
      bus.instruction = ins;
      bus.result_lo   = lo;
      bus.result_hi   = hi;
      bus.base_value  = base;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset wr_en got %b want 0", bus.wr_en); end
      n_tests++;
      if (bus.wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset wr_addr got %0d want 0", bus.wr_addr); end
      n_tests++;
      if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL reset wr_data got %h want 0", bus.wr_data); end
      n_tests++;
      if (bus.pc_written !== 1'b0) begin n_fail++; $display("FAIL reset pc_written got %b want 0", bus.pc_written); end
      n_tests++;
      if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset ld_ready got %b want 0", bus.ld_ready); end
      n_tests++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready got %b want 1", bus.req_ready); end
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", bus.busy); end
   endtask

   task automatic test_add();
      n_tests++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_pre got %b want 1", bus.req_ready); end
      send_req(28'h0813002, 32'h12345678, 32'h0, 32'h0);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'd3, 32'h12345678}) begin
         n_fail++;
         $display("FAIL add_write got en=%b addr=%0d data=%h want en=1 addr=3 data=12345678",
                  bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      n_tests++;
      if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy got ready=%b want 0", bus.req_ready); end
      tick();
      n_tests++;
      if (bus.req_ready !== 1'b1 || bus.wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done got ready=%b en=%b want ready=1 en=0", bus.req_ready, bus.wr_en);
      end
   endtask

   task automatic test_no_write();
      // CMP R1,#5
      send_req(28'h3510005, 32'hDEADBEEF, 32'h0, 32'h0);
      n_tests++;
      if (bus.wr_en !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmp got en=%b ready=%b want en=0 ready=1", bus.wr_en, bus.req_ready);
      end
      // STR R1,[R2] with no writeback
      send_req(28'h5821000, 32'h0, 32'h0, 32'h4444);
      n_tests++;
      if (bus.wr_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL str got en=%b ready=%b ld_ready=%b want 0 1 0",
                  bus.wr_en, bus.req_ready, bus.ld_ready);
      end
   endtask

   task automatic test_dp_special();
      // MRS R3,CPSR
      send_req(28'h10F3000, 32'h600000D3, 32'h0, 32'h0);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written} !== {1'b1, 4'd3, 32'h600000D3, 1'b0}) begin
         n_fail++;
         $display("FAIL mrs got en=%b addr=%0d data=%h pc=%b want 1 3 600000d3 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written);
      end
      tick();
      // MOV PC,LR
      send_req(28'h1A0F00E, 32'h00000100, 32'h0, 32'h0);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written} !== {1'b1, 4'd15, 32'h100, 1'b1}) begin
         n_fail++;
         $display("FAIL mov_pc got en=%b addr=%0d data=%h pc=%b want 1 15 00000100 1",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written);
      end
      tick();
      n_tests++;
      if (bus.pc_written !== 1'b0) begin n_fail++; $display("FAIL mov_pc_pulse got %b want 0", bus.pc_written); end
   endtask

   task automatic test_long_mul();
      send_req(28'h0854291, 32'hAAAA0001, 32'h0000BBBB, 32'h0);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy} !== {1'b1, 4'd4, 32'hAAAA0001, 1'b1}) begin
         n_fail++;
         $display("FAIL umull_lo got en=%b addr=%0d data=%h busy=%b want 1 4 aaaa0001 1",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy);
      end
      tick();
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy} !== {1'b1, 4'd5, 32'h0000BBBB, 1'b1}) begin
         n_fail++;
         $display("FAIL umull_hi got en=%b addr=%0d data=%h busy=%b want 1 5 0000bbbb 1",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy);
      end
      tick();
      n_tests++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL umull_done got en=%b busy=%b want 0 0", bus.wr_en, bus.busy);
      end
   endtask

   task automatic test_ldr_post();
      send_req(28'h4912004, 32'h0, 32'h0, 32'h1004);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.ld_ready} !== {1'b1, 4'd1, 32'h1004, 1'b0}) begin
         n_fail++;
         $display("FAIL ldr_base got en=%b addr=%0d data=%h ld_ready=%b want 1 1 00001004 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.ld_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.ld_ready !== 1'b1 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ldr_wait%0d got ld_ready=%b en=%b want 1 0", i, bus.ld_ready, bus.wr_en);
         end
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hCAFEF00D;
      tick();
      bus.ld_valid = 1'b0;
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready} !== {1'b1, 4'd2, 32'hCAFEF00D, 1'b1}) begin
         n_fail++;
         $display("FAIL ldr_data got en=%b addr=%0d data=%h ready=%b want 1 2 cafef00d 1",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready);
      end
      tick();
   endtask

   task automatic test_ldm();
      send_req(28'h8B0800A, 32'h0, 32'h0, 32'h2000C);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written} !== {1'b1, 4'd0, 32'h2000C, 1'b0}) begin
         n_fail++;
         $display("FAIL ldm_base got en=%b addr=%0d data=%h pc=%b want 1 0 0002000c 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written);
      end
      tick();
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h11;
      tick();
      bus.ld_valid = 1'b0;
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written} !== {1'b1, 4'd1, 32'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL ldm_r1 got en=%b addr=%0d data=%h pc=%b want 1 1 00000011 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (bus.wr_en !== 1'b0 || bus.ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ldm_stall%0d got en=%b ld_ready=%b want 0 1", i, bus.wr_en, bus.ld_ready);
         end
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h33;
      tick();
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready} !== {1'b1, 4'd3, 32'h33, 1'b0}) begin
         n_fail++;
         $display("FAIL ldm_r3 got en=%b addr=%0d data=%h ready=%b want 1 3 00000033 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.req_ready);
      end
      bus.ld_data = 32'hFF0;
      tick();
      bus.ld_valid = 1'b0;
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written, bus.req_ready} !==
          {1'b1, 4'd15, 32'hFF0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL ldm_r15 got en=%b addr=%0d data=%h pc=%b ready=%b want 1 15 00000ff0 1 1",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written, bus.req_ready);
      end
      tick();
      n_tests++;
      if (bus.wr_en !== 1'b0 || bus.pc_written !== 1'b0) begin
         n_fail++;
         $display("FAIL ldm_done got en=%b pc=%b want 0 0", bus.wr_en, bus.pc_written);
      end
   endtask

   task automatic test_bl();
      send_req(28'hB000000, 32'h0804, 32'h0, 32'h0);
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written} !== {1'b1, 4'd14, 32'h0804, 1'b0}) begin
         n_fail++;
         $display("FAIL bl got en=%b addr=%0d data=%h pc=%b want 1 14 00000804 0",
                  bus.wr_en, bus.wr_addr, bus.wr_data, bus.pc_written);
      end
      tick();
   endtask

   task automatic test_reset_mid_ldm();
      send_req(28'h8B0800A, 32'h0, 32'h0, 32'h2000C);
      tick();
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h11;
      tick();
      bus.ld_valid = 1'b0;
      n_tests++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'd1, 32'h11}) begin
         n_fail++;
         $display("FAIL rst_ldm_r1 got en=%b addr=%0d data=%h want 1 1 00000011",
                  bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      #1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.wr_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ldm_async got en=%b ready=%b ld_ready=%b want 0 1 0",
                  bus.wr_en, bus.req_ready, bus.ld_ready);
      end
      tick();
      rst = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h33;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.wr_en !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ldm_after%0d got en=%b ready=%b want 0 1", i, bus.wr_en, bus.req_ready);
         end
      end
      bus.ld_valid = 1'b0;
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.instruction = 28'd0;
      bus.result_lo   = 32'd0;
      bus.result_hi   = 32'd0;
      bus.base_value  = 32'd0;
      bus.ld_valid    = 1'b0;
      bus.ld_data     = 32'd0;
      tick();
      tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_add();
      test_no_write();
      test_dp_special();
      test_long_mul();
      test_ldr_post();
      test_ldm();
      test_bl();
      test_reset_mid_ldm();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
